csi2_tx_packetizer: RTL and testbench

CSI2_TX_PACKETIZER -- requirements
Module: csi2_tx_packetizer

---
 rtl/csi2_tx_packetizer.sv | 244 ++++++++++++++++++++++++
 tb/tb_csi2_tx_packetizer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_tx_packetizer.sv
// rtl/csi2_tx_packetizer.sv - CSI-2 TX packet framer: short/long headers with ECC, payload pass-through, CRC-16 footer
//
// Purpose: turns short-packet requests and long-packet header+payload requests into a
// 32-bit word stream for the D-PHY master. Each header word carries {ECC, WC/data field, VC, DT}.
// Long packets get a CRC-16 footer packed directly after the last payload byte.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   short_pkt_*                       short packet request (valid/ready + VC, DT, 16-bit data field)
//   long_pkt_header_*, long_pkt_v_channel_i, long_pkt_data_type_i, long_pkt_word_cnt_i
//                                     long packet header request (WC = payload byte count)
//   long_pkt_payload_*, long_pkt_eop_i
//                                     payload word stream, byte0 in [7:0], be contiguous from byte0
//   data_o, be_o, valid_o, ready_i, sop_o, eop_o
//                                     registered output word stream
//   wc_error_o                        one-cycle pulse when the payload byte total differs from WC
module csi2_tx_packetizer #(
    parameter bit SHORT_PRIORITY = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        short_pkt_valid_i,
    output logic        short_pkt_ready_o,
    input  logic [1:0]  short_pkt_v_channel_i,
    input  logic [5:0]  short_pkt_data_type_i,
    input  logic [15:0] short_pkt_data_field_i,
    input  logic        long_pkt_header_valid_i,
    output logic        long_pkt_header_ready_o,
    input  logic [1:0]  long_pkt_v_channel_i,
    input  logic [5:0]  long_pkt_data_type_i,
    input  logic [15:0] long_pkt_word_cnt_i,
    input  logic [31:0] long_pkt_payload_i,
    input  logic        long_pkt_payload_valid_i,
    output logic        long_pkt_payload_ready_o,
    input  logic [3:0]  long_pkt_payload_be_i,
    input  logic        long_pkt_eop_i,
    output logic [31:0] data_o,
    output logic [3:0]  be_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        sop_o,
    output logic        eop_o,
    output logic        wc_error_o
);
    typedef enum logic [2:0] {IDLE, SHORT_HDR, LONG_HDR, PAYLOAD, FOOTER} state_t;

    state_t      state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [16:0] cnt_q, cnt_d;
    logic [15:0] wc_q, wc_d;
    logic        foot_one_q, foot_one_d;   // footer word holds only the CRC high byte
    logic        rdy_en_q;                 // keeps request readies low for one cycle after reset

    logic        load;
    logic [31:0] ld_data;
    logic [3:0]  ld_be;
    logic        ld_sop, ld_eop, wc_err_d;

    logic        out_free, idle_free, short_acc, long_acc, pay_acc;
    logic [23:0] short_hdr, long_hdr;
    logic [2:0]  k;
    logic [15:0] crc_new;
    logic [16:0] cnt_new;

    // Each parity bit is the XOR of the header bits selected by its row mask.
    function automatic logic [5:0] ecc6(input logic [23:0] h);
        logic [5:0] p;
        p[0] = ^(h & 24'hF12CB7);
        p[1] = ^(h & 24'hF2555B);
        p[2] = ^(h & 24'h749A6D);
        p[3] = ^(h & 24'hB8E38E);
        p[4] = ^(h & 24'hDF03F0);
        p[5] = ^(h & 24'hEFFC00);
        return p;
    endfunction

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    assign out_free  = !valid_o || ready_i;
    assign idle_free = (state_q == IDLE) && out_free && rdy_en_q;

    // Ready depends on the competing valid so that only one request can transfer per cycle.
    assign short_pkt_ready_o        = idle_free && (SHORT_PRIORITY || !long_pkt_header_valid_i);
    assign long_pkt_header_ready_o  = idle_free && (!SHORT_PRIORITY || !short_pkt_valid_i);
    assign long_pkt_payload_ready_o = (state_q == PAYLOAD) && out_free;

    assign short_acc = short_pkt_valid_i && short_pkt_ready_o;
    assign long_acc  = long_pkt_header_valid_i && long_pkt_header_ready_o;
    assign pay_acc   = long_pkt_payload_valid_i && long_pkt_payload_ready_o;

    assign short_hdr = {short_pkt_data_field_i, short_pkt_v_channel_i, short_pkt_data_type_i};
    assign long_hdr  = {long_pkt_word_cnt_i, long_pkt_v_channel_i, long_pkt_data_type_i};

    always_comb begin
        k = 3'd4;
        case (long_pkt_payload_be_i)
            4'h1:    k = 3'd1;
            4'h3:    k = 3'd2;
            4'h7:    k = 3'd3;
            default: k = 3'd4;
        endcase
        crc_new = crc_q;
        for (int j = 0; j < 4; j++) begin
            if (long_pkt_payload_be_i[j]) begin
                crc_new = crc_byte(crc_new, long_pkt_payload_i[8*j +: 8]);
            end
        end
        cnt_new = cnt_q + {14'd0, k};
    end

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        wc_d       = wc_q;
        foot_one_d = foot_one_q;
        load       = 1'b0;
        ld_data    = '0;
        ld_be      = '0;
        ld_sop     = 1'b0;
        ld_eop     = 1'b0;
        wc_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (short_acc) begin
                    load    = 1'b1;
                    ld_data = {2'b00, ecc6(short_hdr), short_hdr};
                    ld_be   = 4'hF;
                    ld_sop  = 1'b1;
                    ld_eop  = 1'b1;
                    state_d = SHORT_HDR;
                end else if (long_acc) begin
                    load    = 1'b1;
                    ld_data = {2'b00, ecc6(long_hdr), long_hdr};
                    ld_be   = 4'hF;
                    ld_sop  = 1'b1;
                    crc_d   = 16'hFFFF;
                    cnt_d   = '0;
                    wc_d    = long_pkt_word_cnt_i;
                    state_d = LONG_HDR;
                end
            end
            SHORT_HDR: begin
                if (valid_o && ready_i) state_d = IDLE;
            end
            LONG_HDR: begin
                if (valid_o && ready_i) begin
                    foot_one_d = 1'b0;
                    state_d    = (wc_q == 16'd0) ? FOOTER : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (pay_acc) begin
                    crc_d   = crc_new;
                    cnt_d   = cnt_new;
                    load    = 1'b1;
                    ld_data = long_pkt_payload_i;
                    ld_be   = long_pkt_payload_be_i;
                    if (long_pkt_eop_i) begin
                        wc_err_d = (cnt_new != {1'b0, wc_q});
                        // The two CRC bytes follow the last payload byte; whatever does
                        // not fit in this word spills into a FOOTER word.
                        case (k)
                            3'd1: begin
                                ld_data = {8'h00, crc_new, long_pkt_payload_i[7:0]};
                                ld_be   = 4'h7;
                                ld_eop  = 1'b1;
                                state_d = IDLE;
                            end
                            3'd2: begin
                                ld_data = {crc_new, long_pkt_payload_i[15:0]};
                                ld_be   = 4'hF;
                                ld_eop  = 1'b1;
                                state_d = IDLE;
                            end
                            3'd3: begin
                                ld_data    = {crc_new[7:0], long_pkt_payload_i[23:0]};
                                ld_be      = 4'hF;
                                foot_one_d = 1'b1;
                                state_d    = FOOTER;
                            end
                            default: begin
                                ld_be      = 4'hF;
                                foot_one_d = 1'b0;
                                state_d    = FOOTER;
                            end
                        endcase
                    end
                end
            end
            FOOTER: begin
                if (out_free) begin
                    load    = 1'b1;
                    ld_data = foot_one_q ? {24'h0, crc_q[15:8]} : {16'h0, crc_q};
                    ld_be   = foot_one_q ? 4'h1 : 4'h3;
                    ld_eop  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            crc_q      <= 16'hFFFF;
            cnt_q      <= '0;
            wc_q       <= '0;
            foot_one_q <= 1'b0;
            rdy_en_q   <= 1'b0;
            valid_o    <= 1'b0;
            data_o     <= '0;
            be_o       <= '0;
            sop_o      <= 1'b0;
            eop_o      <= 1'b0;
            wc_error_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            wc_q       <= wc_d;
            foot_one_q <= foot_one_d;
            rdy_en_q   <= 1'b1;
            wc_error_o <= wc_err_d;
            if (load) begin
                valid_o <= 1'b1;
                data_o  <= ld_data;
                be_o    <= ld_be;
                sop_o   <= ld_sop;
                eop_o   <= ld_eop;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_csi2_tx_packetizer.sv
// tb/tb_csi2_tx_packetizer.sv - self-checking bench for csi2_tx_packetizer
module tb_csi2_tx_packetizer;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        short_pkt_valid_i, short_pkt_ready_o;
    logic [1:0]  short_pkt_v_channel_i;
    logic [5:0]  short_pkt_data_type_i;
    logic [15:0] short_pkt_data_field_i;
    logic        long_pkt_header_valid_i, long_pkt_header_ready_o;
    logic [1:0]  long_pkt_v_channel_i;
    logic [5:0]  long_pkt_data_type_i;
    logic [15:0] long_pkt_word_cnt_i;
    logic [31:0] long_pkt_payload_i;
    logic        long_pkt_payload_valid_i, long_pkt_payload_ready_o;
    logic [3:0]  long_pkt_payload_be_i;
    logic        long_pkt_eop_i;
    logic [31:0] data_o;
    logic [3:0]  be_o;
    logic        valid_o, ready_i, sop_o, eop_o, wc_error_o;

    always #5 clk_i = ~clk_i;

    csi2_tx_packetizer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .short_pkt_valid_i(short_pkt_valid_i), .short_pkt_ready_o(short_pkt_ready_o),
        .short_pkt_v_channel_i(short_pkt_v_channel_i), .short_pkt_data_type_i(short_pkt_data_type_i),
        .short_pkt_data_field_i(short_pkt_data_field_i),
        .long_pkt_header_valid_i(long_pkt_header_valid_i), .long_pkt_header_ready_o(long_pkt_header_ready_o),
        .long_pkt_v_channel_i(long_pkt_v_channel_i), .long_pkt_data_type_i(long_pkt_data_type_i),
        .long_pkt_word_cnt_i(long_pkt_word_cnt_i),
        .long_pkt_payload_i(long_pkt_payload_i), .long_pkt_payload_valid_i(long_pkt_payload_valid_i),
        .long_pkt_payload_ready_o(long_pkt_payload_ready_o), .long_pkt_payload_be_i(long_pkt_payload_be_i),
        .long_pkt_eop_i(long_pkt_eop_i),
        .data_o(data_o), .be_o(be_o), .valid_o(valid_o), .ready_i(ready_i),
        .sop_o(sop_o), .eop_o(eop_o), .wc_error_o(wc_error_o)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  be;
        logic        sop;
        logic        eop;
    } word_t;

    // Syndrome column of each header data bit.
    localparam logic [5:0] ECC_COL [0:23] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
    localparam logic [7:0] REF_PAY [0:23] = '{
        8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
        8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
        8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    localparam int WCS [0:5] = '{1, 2, 3, 5, 6, 7};

    int          n_checks = 0;
    int          n_fails = 0;
    int          wc_err_cycles = 0;
    int          pay_rdy_cycles = 0;
    logic        rand_ready = 1'b0;
    word_t       exp_q[$];
    logic [7:0]  pay_bytes[$];
    word_t       e;
    logic        prev_stall = 1'b0;
    logic [38:0] prev_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] model_ecc(input logic [23:0] h);
        logic [5:0] r = 6'h00;
        for (int i = 0; i < 24; i++) if (h[i]) r = r ^ ECC_COL[i];
        return r;
    endfunction

    // Bit-serial LSB-first CRC over pay_bytes.
    function automatic logic [15:0] model_crc();
        logic [15:0] c = 16'hFFFF;
        logic fb;
        foreach (pay_bytes[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ pay_bytes[i][b];
                c = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    task automatic model_short(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] fld);
        word_t w;
        logic [23:0] h;
        h = {fld, vc, dt};
        w.data = {2'b00, model_ecc(h), h};
        w.be = 4'hF; w.sop = 1'b1; w.eop = 1'b1;
        exp_q.push_back(w);
    endtask

    // Header, then payload bytes followed by CRC lo/hi, packed four bytes per word.
    task automatic model_long(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
        word_t w;
        logic [23:0] h;
        logic [15:0] c;
        logic [7:0] s[$];
        int n;
        h = {wc, vc, dt};
        w.data = {2'b00, model_ecc(h), h};
        w.be = 4'hF; w.sop = 1'b1; w.eop = 1'b0;
        exp_q.push_back(w);
        c = model_crc();
        s = pay_bytes;
        s.push_back(c[7:0]);
        s.push_back(c[15:8]);
        n = s.size();
        for (int i = 0; i < n; i += 4) begin
            w.data = '0; w.be = '0; w.sop = 1'b0; w.eop = (i + 4 >= n);
            for (int b = 0; b < 4; b++) begin
                if (i + b < n) begin
                    w.data[8*b +: 8] = s[i+b];
                    w.be[b] = 1'b1;
                end
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic set_seq_payload(input int n, input int start);
        pay_bytes.delete();
        for (int i = 0; i < n; i++) pay_bytes.push_back(8'(start + i * 37));
    endtask

    task automatic load_ref_payload();
        pay_bytes.delete();
        for (int i = 0; i < 24; i++) pay_bytes.push_back(REF_PAY[i]);
    endtask

    // which: 0 short ready, 1 long header ready, 2 payload ready. Returns at posedge+1 after the transfer.
    task automatic wait_ready(input int which, input string name);
        logic r;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_i);
            r = (which == 0) ? short_pkt_ready_o : (which == 1) ? long_pkt_header_ready_o : long_pkt_payload_ready_o;
            if (r) begin
                @(posedge clk_i); #1;
                return;
            end
        end
        n_checks++; n_fails++;
        $display("FAIL %s: handshake timeout", name);
        @(posedge clk_i); #1;
    endtask

    task automatic drive_payload();
        int nb, nw;
        logic [31:0] word;
        logic [3:0] be;
        nb = pay_bytes.size();
        nw = (nb + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            word = 32'hEEEEEEEE; be = 4'h0;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < nb) begin
                    word[8*b +: 8] = pay_bytes[4*w+b];
                    be[b] = 1'b1;
                end
            end
            long_pkt_payload_i = word;
            long_pkt_payload_be_i = be;
            long_pkt_eop_i = (w == nw - 1);
            long_pkt_payload_valid_i = 1'b1;
            wait_ready(2, "payload_hs");
        end
        if (nw > 0) begin
            long_pkt_payload_valid_i = 1'b0;
            long_pkt_eop_i = 1'b0;
        end
    endtask

    task automatic send_short(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] fld);
        model_short(vc, dt, fld);
        short_pkt_v_channel_i = vc; short_pkt_data_type_i = dt; short_pkt_data_field_i = fld;
        short_pkt_valid_i = 1'b1;
        wait_ready(0, "short_hs");
        short_pkt_valid_i = 1'b0;
    endtask

    task automatic send_long(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
        model_long(vc, dt, wc);
        long_pkt_v_channel_i = vc; long_pkt_data_type_i = dt; long_pkt_word_cnt_i = wc;
        long_pkt_header_valid_i = 1'b1;
        wait_ready(1, "long_hs");
        long_pkt_header_valid_i = 1'b0;
        drive_payload();
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 1000) begin
            @(posedge clk_i); #2;
            cyc++;
        end
        check(name, exp_q.size(), 0);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", {valid_o, data_o, be_o, sop_o, eop_o}, prev_out);
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fails++;
                    $display("FAIL unexpected_word: got %h be %h with none expected", data_o, be_o);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {data_o, be_o, sop_o, eop_o}, {e.data, e.be, e.sop, e.eop});
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_out = {valid_o, data_o, be_o, sop_o, eop_o};
            if (wc_error_o) wc_err_cycles++;
            if (long_pkt_payload_ready_o) pay_rdy_cycles++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0, p0;
        rst_i = 1'b1;
        short_pkt_valid_i = 0; short_pkt_v_channel_i = 0; short_pkt_data_type_i = 0; short_pkt_data_field_i = 0;
        long_pkt_header_valid_i = 0; long_pkt_v_channel_i = 0; long_pkt_data_type_i = 0; long_pkt_word_cnt_i = 0;
        long_pkt_payload_i = 0; long_pkt_payload_valid_i = 0; long_pkt_payload_be_i = 0; long_pkt_eop_i = 0;

        // Hand-computed pins on the model itself.
        check("pin_ecc_d0", model_ecc(24'h000001), 6'h07);
        check("pin_ecc_2a_wc24", model_ecc({16'd24, 8'h2A}), 6'h13);
        load_ref_payload();
        check("pin_crc_ref", model_crc(), 16'h00F0);
        model_long(2'd0, 6'h2A, 16'd24);
        check("pin_ref_words", exp_q.size(), 8);
        check("pin_ref_header", exp_q[0].data, 32'h1300182A);
        check("pin_ref_footer", {exp_q[7].data, exp_q[7].be, exp_q[7].eop}, {32'h000000F0, 4'h3, 1'b1});
        exp_q.delete();

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_outputs", {valid_o, sop_o, eop_o, be_o, data_o, wc_error_o}, '0);
        check("rst_readies", {short_pkt_ready_o, long_pkt_header_ready_o, long_pkt_payload_ready_o}, 3'b000);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("release_cycle1_readies", {short_pkt_ready_o, long_pkt_header_ready_o, long_pkt_payload_ready_o}, 3'b000);
        @(negedge clk_i);
        check("release_cycle2_readies", {short_pkt_ready_o, long_pkt_header_ready_o, long_pkt_payload_ready_o}, 3'b110);
        check("idle_valid_low", valid_o, 1'b0);
        @(posedge clk_i); #1;

        // Short packet literal.
        send_short(2'd0, 6'h01, 16'h0000);
        @(negedge clk_i);
        check("short_literal", {valid_o, data_o, be_o, sop_o, eop_o}, {1'b1, 32'h07000001, 4'hF, 1'b1, 1'b1});
        wait_drain("drain_short");

        for (int mode = 0; mode < 2; mode++) begin
            rand_ready = (mode == 1);
            e0 = wc_err_cycles;

            load_ref_payload();
            send_long(2'd0, 6'h2A, 16'd24);
            wait_drain("drain_ref");

            // WC=0 with stray payload valid held high: must be ignored.
            p0 = pay_rdy_cycles;
            pay_bytes.delete();
            long_pkt_payload_i = 32'hDEADBEEF; long_pkt_payload_be_i = 4'hF; long_pkt_payload_valid_i = 1'b1;
            send_long(2'd1, 6'h12, 16'd0);
            wait_drain("drain_wc0");
            long_pkt_payload_valid_i = 1'b0;
            check("wc0_no_payload_ready", pay_rdy_cycles - p0, 0);

            for (int i = 0; i < 6; i++) begin
                set_seq_payload(WCS[i], 16 * i + mode);
                send_long(2'(i), 6'h2B, 16'(WCS[i]));
                wait_drain("drain_kvar");
            end
            check("no_wc_error_when_matching", wc_err_cycles - e0, 0);

            e0 = wc_err_cycles;
            set_seq_payload(4, 8'h40);
            send_long(2'd2, 6'h2C, 16'd8);
            wait_drain("drain_wc_mismatch");
            check("wc_error_single_pulse", wc_err_cycles - e0, 1);

            // Both requests together: short must go first.
            model_short(2'd2, 6'h10, 16'hBEEF);
            set_seq_payload(5, 8'h77);
            model_long(2'd3, 6'h2B, 16'd5);
            short_pkt_v_channel_i = 2'd2; short_pkt_data_type_i = 6'h10; short_pkt_data_field_i = 16'hBEEF;
            long_pkt_v_channel_i = 2'd3; long_pkt_data_type_i = 6'h2B; long_pkt_word_cnt_i = 16'd5;
            short_pkt_valid_i = 1'b1; long_pkt_header_valid_i = 1'b1;
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk_i);
                if (short_pkt_ready_o) begin
                    check("long_held_off", long_pkt_header_ready_o, 1'b0);
                    break;
                end
            end
            @(posedge clk_i); #1;
            short_pkt_valid_i = 1'b0;
            wait_ready(1, "long_hs_after_short");
            long_pkt_header_valid_i = 1'b0;
            drive_payload();
            wait_drain("drain_both");
        end

        // Reset in the middle of a long packet.
        rand_ready = 1'b0;
        @(posedge clk_i); #1;
        set_seq_payload(8, 8'h10);
        model_long(2'd0, 6'h2C, 16'd8);
        long_pkt_v_channel_i = 2'd0; long_pkt_data_type_i = 6'h2C; long_pkt_word_cnt_i = 16'd8;
        long_pkt_header_valid_i = 1'b1;
        wait_ready(1, "long_hs_mid_rst");
        long_pkt_header_valid_i = 1'b0;
        long_pkt_payload_i = 32'h44332211; long_pkt_payload_be_i = 4'hF; long_pkt_eop_i = 1'b0;
        long_pkt_payload_valid_i = 1'b1;
        wait_ready(2, "payload_hs_mid_rst");
        rst_i = 1'b1;
        long_pkt_payload_valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("mid_rst_outputs", {valid_o, eop_o, long_pkt_payload_ready_o}, 3'b000);
        exp_q.delete();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_rst_release_c1", {short_pkt_ready_o, long_pkt_header_ready_o}, 2'b00);
        @(negedge clk_i);
        check("mid_rst_release_c2", {short_pkt_ready_o, long_pkt_header_ready_o}, 2'b11);
        @(posedge clk_i); #1;
        send_short(2'd1, 6'h02, 16'h1234);
        wait_drain("drain_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
